// File: rtl/arbiter_pkg.sv
// Shared types and constants for the round-robin lock arbiter.
package arbiter_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } rr_arb_state_t;

    localparam int unsigned BUSY_CNT_WIDTH = 8;

endpackage

// File: rtl/priority_finder.sv
// Priority finder: reports whether any bit of req is set and the index of the
// winning bit. FIRST_PRIORITY=1 picks the lowest set index, 0 picks the highest.
//   req   : request vector
//   found : at least one bit set
//   idx   : index of the selected bit (0 when found=0)
module priority_finder #(
    parameter int unsigned WIDTH          = 4,
    parameter bit          FIRST_PRIORITY = 1'b1,
    parameter int unsigned IDX_WIDTH      = 2
) (
    input  logic [WIDTH-1:0]     req,
    output logic                 found,
    output logic [IDX_WIDTH-1:0] idx
);

    // Later loop iterations override earlier ones, so scan direction sets priority.
    always_comb begin
        found = |req;
        idx   = '0;
        if (FIRST_PRIORITY) begin
            for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
                if (req[i]) idx = IDX_WIDTH'(i);
            end
        end else begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (req[i]) idx = IDX_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter sharing one multi-cycle resource among REQ_NUM requesters.
// A winner keeps the grant until the resource releases it; the pointer then
// moves past the winner and re-arbitration happens in the same cycle.
//   clk, rst         : clock, asynchronous active-high reset
//   req              : per-requester request level
//   resource_release : resource finished the current transaction (GRANT only)
//   flush            : cancels the current grant, highest priority
//   grant            : one-hot grant vector (registered)
//   grant_id         : binary index of the granted requester (registered)
//   grant_valid      : a grant is active (registered)
//   busy_cycles      : cycles the current grant has been held, saturating
module rr_lock_arbiter
    import arbiter_pkg::*;
#(
    parameter int unsigned REQ_NUM  = 4,
    parameter int unsigned ID_WIDTH = (($clog2(REQ_NUM) > 1) ? $clog2(REQ_NUM) - 1 : 0) + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REQ_NUM-1:0]        req,
    input  logic                      resource_release,
    input  logic                      flush,
    output logic [REQ_NUM-1:0]        grant,
    output logic [ID_WIDTH-1:0]       grant_id,
    output logic                      grant_valid,
    output logic [BUSY_CNT_WIDTH-1:0] busy_cycles
);

    rr_arb_state_t             state_q, state_d;
    logic [ID_WIDTH-1:0]       ptr_q, ptr_d;
    logic [REQ_NUM-1:0]        grant_d;
    logic [ID_WIDTH-1:0]       grant_id_d;
    logic                      grant_valid_d;
    logic [BUSY_CNT_WIDTH-1:0] busy_d;

    logic [ID_WIDTH-1:0]       ptr_inc_c;
    logic [ID_WIDTH-1:0]       arb_ptr_c;
    logic [REQ_NUM-1:0]        arb_req_c;
    logic [REQ_NUM-1:0]        mask_c;
    logic [REQ_NUM-1:0]        masked_c;
    logic                      m_found_c, r_found_c;
    logic [ID_WIDTH-1:0]       m_idx_c, r_idx_c;
    logic [ID_WIDTH-1:0]       winner_c;

    // Pointer just past the current holder, wrapping at REQ_NUM-1.
    assign ptr_inc_c = (grant_id == ID_WIDTH'(REQ_NUM - 1)) ? '0 : grant_id + ID_WIDTH'(1);

    // In GRANT the candidate set excludes the releasing holder and uses the advanced pointer.
    always_comb begin
        arb_req_c = req;
        arb_ptr_c = ptr_q;
        if (state_q == GRANT) begin
            arb_req_c = req & ~grant;
            arb_ptr_c = ptr_inc_c;
        end
        for (int unsigned i = 0; i < REQ_NUM; i++) begin
            mask_c[i] = (i >= 32'(arb_ptr_c));
        end
        masked_c = arb_req_c & mask_c;
    end

    priority_finder #(
        .WIDTH          (REQ_NUM),
        .FIRST_PRIORITY (1'b1),
        .IDX_WIDTH      (ID_WIDTH)
    ) u_pf_masked (
        .req   (masked_c),
        .found (m_found_c),
        .idx   (m_idx_c)
    );

    priority_finder #(
        .WIDTH          (REQ_NUM),
        .FIRST_PRIORITY (1'b1),
        .IDX_WIDTH      (ID_WIDTH)
    ) u_pf_raw (
        .req   (arb_req_c),
        .found (r_found_c),
        .idx   (r_idx_c)
    );

    assign winner_c = m_found_c ? m_idx_c : r_idx_c;

    // Next-state and output logic.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        grant_d       = grant;
        grant_id_d    = grant_id;
        grant_valid_d = grant_valid;
        busy_d        = busy_cycles;

        if (flush) begin
            state_d       = IDLE;
            grant_d       = '0;
            grant_id_d    = '0;
            grant_valid_d = 1'b0;
            busy_d        = '0;
            // A release alongside flush still completed the transaction.
            if (state_q == GRANT && resource_release) ptr_d = ptr_inc_c;
        end else begin
            case (state_q)
                IDLE: begin
                    if (r_found_c) begin
                        state_d       = GRANT;
                        grant_d       = REQ_NUM'(1) << winner_c;
                        grant_id_d    = winner_c;
                        grant_valid_d = 1'b1;
                        busy_d        = '0;
                    end
                end
                GRANT: begin
                    if (resource_release) begin
                        ptr_d = ptr_inc_c;
                        if (r_found_c) begin
                            grant_d    = REQ_NUM'(1) << winner_c;
                            grant_id_d = winner_c;
                            busy_d     = '0;
                        end else begin
                            state_d       = IDLE;
                            grant_d       = '0;
                            grant_id_d    = '0;
                            grant_valid_d = 1'b0;
                            busy_d        = '0;
                        end
                    end else if (busy_cycles != '1) begin
                        busy_d = busy_cycles + BUSY_CNT_WIDTH'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            grant       <= '0;
            grant_id    <= '0;
            grant_valid <= 1'b0;
            busy_cycles <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant       <= grant_d;
            grant_id    <= grant_id_d;
            grant_valid <= grant_valid_d;
            busy_cycles <= busy_d;
        end
    end

    // Holder must keep requesting until its transaction is released.
    a_req_held: assert property (@(posedge clk) disable iff (rst)
        (grant_valid && !resource_release && !flush) |-> |(req & grant));

    // One-hot grant always matches grant_id, and is zero when idle.
    a_grant_consistent: assert property (@(posedge clk) disable iff (rst)
        grant == (grant_valid ? (REQ_NUM'(1) << grant_id) : '0));

endmodule

// File: doc/rr_lock_arbiter.md
Name: rr_lock_arbiter

Overview:
- Round-robin arbiter that shares one multi-cycle resource (e.g. a CSR/bus/divider port) among REQ_NUM requesters.
- A winner holds the grant until the resource signals `release`.
- The pointer then advances past the winner, giving fair rotation.
- Winner selection uses two instances of the existing priority_finder (masked and unmasked request vectors).

Parameters:
- REQ_NUM, 4, number of requesters; must be a power of 2, at least 2.
- ID_WIDTH, `max($clog2(REQ_NUM) - 1, 0) + 1, width of the requester index (derived; not overridden).

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous reset, active-high
- req  input  REQ_NUM  per-requester request level
- release  input  1  resource finished current transaction; valid only while grant_valid=1
- flush  input  1  pipeline flush; synchronously cancels the current grant
- grant  output  REQ_NUM  one-hot grant vector, registered
- grant_id  output  ID_WIDTH  binary index of the granted requester, registered
- grant_valid  output  1  a grant is active, registered
- busy_cycles  output  8  cycles the current grant has been held, saturating at 255

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE, pointer=0.
  - grant=0, grant_id=0, grant_valid=0, busy_cycles=0.
- State IDLE:
  - If |req: compute masked = req & mask, where mask bit i = 1 for i >= pointer.
  - If masked is nonzero, winner = lowest set index of masked; else winner = lowest set index of req.
  - Next state GRANT; grant_valid=1, grant=1<<winner, grant_id=winner, busy_cycles=0.
  - If no req: stay in IDLE, outputs unchanged (grant_valid=0).
  - Latency: req asserted in cycle t -> grant visible in cycle t+1.
- State GRANT:
  - Grant is held, independent of req, until release or flush.
  - busy_cycles increments by 1 each cycle, saturating at 255.
- release=1 in GRANT:
  - pointer <= grant_id+1, modulo REQ_NUM (grant_id=REQ_NUM-1 wraps to 0).
  - Same cycle, re-arbitrate using the updated pointer and the current req, excluding the releasing requester's bit.
  - If a winner exists: stay in GRANT with the new grant, busy_cycles=0. Back-to-back, no bubble.
  - Else: go to IDLE, grant_valid=0, grant=0.
  - The releasing requester may win again only in a later cycle.
- flush=1: highest priority, in either state.
  - Next state IDLE; grant=0, grant_valid=0, busy_cycles=0; pointer unchanged.
  - No arbitration occurs in the flush cycle.
- flush and release in the same cycle: flush wins, and the pointer still advances, because release completed the transaction.
- release while not in GRANT: ignored.
- A granted requester that drops req before release: grant is kept. This is a protocol violation and is flagged by assertion.
- grant_id and grant always agree; grant is zero when grant_valid=0.
- rst asserted mid-GRANT: immediate return to reset values; the in-flight transaction is abandoned.

Decomposition:
- Shared package (arbiter_pkg):
  - state enum rr_arb_state_t {IDLE, GRANT}.
  - BUSY_CNT_WIDTH = 8.
- Sub-module: priority_finder, FIRST_PRIORITY=1, WIDTH=REQ_NUM, instantiated twice (masked and raw request). No new sub-module.
- The mask generator and the pointer-increment wrap are local combinational logic.

Test Plan:
1. Reset then req=4'b0000 for 5 cycles -> grant_valid=0, grant=0, grant_id=0, busy_cycles=0 throughout.
2. req=4'b1010 at cycle 1, pointer=0 -> cycle 2: grant=4'b0010, grant_id=1. Hold 3 cycles -> busy_cycles=3. Release -> next cycle grant=4'b1000, grant_id=3, pointer=2.
3. Wrap-around: pointer=3 with id 3 granted, req=4'b1001, release -> next grant_id=0 (id 3 excluded), pointer=0. Next release with req=4'b1001 -> grant_id=3.
4. Fairness: req=4'b1111 constant, release every 2nd cycle -> grant_id sequence 0,1,2,3,0,... with no bubble cycles.
5. flush during GRANT (grant_id=2, pointer=0) -> next cycle grant_valid=0, pointer=0. Re-request with req=4'b0100 -> grant_id=2 one cycle later. flush+release same cycle -> grant_valid=0, pointer=3.
6. Async reset mid-GRANT (grant_id=1, busy_cycles=40) -> outputs zero immediately, before the next edge. busy_cycles saturates at 255 in a separate 300-cycle hold.
